// File: rtl/mat_print_pkg.sv
// Shared constants and state encoding for the matrix text printer.
// Define MAT_PRINT_HEADER_EN to prefix the dump with a "Result:" CR LF header line.
package mat_print_pkg;

   localparam int DEF_ELEM_W     = 17;
   localparam int DEF_DIM        = 3;
   localparam int DEF_HEX_DIGITS = 5;

   localparam logic [7:0] ASC_SP = 8'h20;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;

`ifdef MAT_PRINT_HEADER_EN
   localparam int HDR_LEN = 9;
   localparam logic [0:HDR_LEN-1][7:0] HDR_STR =
      {8'h52, 8'h65, 8'h73, 8'h75, 8'h6C, 8'h74, 8'h3A, 8'h0D, 8'h0A};
`endif

   typedef enum logic [2:0] {IDLE, HDR, DIGIT, SEP, CR, LF, DONE} state_t;

endpackage

// File: rtl/mat_print_nib2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module nib2ascii (
   input  logic [3:0] nib,
   output logic [7:0] asc
);

   assign asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

endmodule

// File: rtl/mat_print.sv
// Captures a DIM x DIM result matrix and streams it as ASCII hex text over valid/ready.
// Optional MAT_PRINT_HEADER_EN adds a "Result:" CR LF header before the data.
module mat_print
   import mat_print_pkg::*;
#(
   parameter int ELEM_W     = DEF_ELEM_W,
   parameter int DIM        = DEF_DIM,
   parameter int HEX_DIGITS = DEF_HEX_DIGITS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [0:DIM*DIM*ELEM_W-1] C_mat,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy,
   output logic                      done
);

   localparam int N   = DIM*DIM*ELEM_W;
   localparam int IW  = $clog2(N);
   localparam int CW  = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int DW  = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;
   localparam int XW  = HEX_DIGITS*4;
   localparam int XIW = $clog2(XW);

   state_t          state_q, state_d;
   logic [0:N-1]    cap_q;
   logic [CW-1:0]   row_q, col_q;
   logic [DW-1:0]   digit_q;
`ifdef MAT_PRINT_HEADER_EN
   localparam int HW = $clog2(HDR_LEN);
   logic [HW-1:0]   hdr_q;
`endif

   logic            xfer;
   logic [IW-1:0]   elem_base;
   logic [ELEM_W-1:0] elem;
   logic [XW-1:0]   elem_ext;
   logic [XIW-1:0]  nib_base;
   logic [3:0]      nib;
   logic [7:0]      nib_asc;

   assign xfer = tx_valid && tx_ready;

   // Element is zero-extended so the top digit only carries the leftover bits.
   assign elem_base = IW'((int'(row_q)*DIM + int'(col_q))*ELEM_W);
   assign elem      = cap_q[elem_base +: ELEM_W];
   assign elem_ext  = XW'(elem);
   assign nib_base  = XIW'({digit_q, 2'b00});
   assign nib       = elem_ext[nib_base +: 4];

   nib2ascii u_nib2ascii (
      .nib (nib),
      .asc (nib_asc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) begin
`ifdef MAT_PRINT_HEADER_EN
            state_d = HDR;
`else
            state_d = DIGIT;
`endif
         end
`ifdef MAT_PRINT_HEADER_EN
         HDR:   if (xfer && hdr_q == HW'(HDR_LEN-1)) state_d = DIGIT;
`endif
         DIGIT: if (xfer && digit_q == '0) state_d = (col_q == CW'(DIM-1)) ? CR : SEP;
         SEP:   if (xfer) state_d = DIGIT;
         CR:    if (xfer) state_d = LF;
         LF:    if (xfer) state_d = (row_q == CW'(DIM-1)) ? DONE : DIGIT;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output byte is a pure function of the registered state, so it holds while stalled.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
`ifdef MAT_PRINT_HEADER_EN
         HDR:   begin tx_valid = 1'b1; busy = 1'b1; tx_data = HDR_STR[hdr_q]; end
`endif
         DIGIT: begin tx_valid = 1'b1; busy = 1'b1; tx_data = nib_asc;   end
         SEP:   begin tx_valid = 1'b1; busy = 1'b1; tx_data = ASC_SP;    end
         CR:    begin tx_valid = 1'b1; busy = 1'b1; tx_data = ASC_CR;    end
         LF:    begin tx_valid = 1'b1; busy = 1'b1; tx_data = ASC_LF;    end
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         digit_q <= '0;
`ifdef MAT_PRINT_HEADER_EN
         hdr_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start) begin
               cap_q   <= C_mat;
               row_q   <= '0;
               col_q   <= '0;
               digit_q <= DW'(HEX_DIGITS-1);
`ifdef MAT_PRINT_HEADER_EN
               hdr_q   <= '0;
`endif
            end
`ifdef MAT_PRINT_HEADER_EN
            HDR:   if (xfer) hdr_q <= hdr_q + 1'b1;
`endif
            DIGIT: if (xfer) digit_q <= (digit_q == '0) ? DW'(HEX_DIGITS-1) : digit_q - 1'b1;
            SEP:   if (xfer) col_q <= col_q + 1'b1;
            LF:    if (xfer) begin
               row_q <= row_q + 1'b1;
               col_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_print.sv
// Scoreboard bench for mat_print: expected text built from the matrix, compared byte by byte.
module tb_mat_print;

   localparam int DIM = 3;
   localparam int EW  = 17;
   localparam int NE  = DIM*DIM;
`ifdef MAT_PRINT_HEADER_EN
   localparam int NB  = 66;
`else
   localparam int NB  = 57;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             tx_ready = 1'b1;
   logic [0:NE*EW-1] C_mat = '0;
   logic [7:0]       tx_data;
   logic             tx_valid, busy, done;

   mat_print dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .C_mat    (C_mat),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];
   int         xfer_total = 0;
   int         done_cnt = 0;
   int         run_base = 0;
   int         mode = 0;
   logic [16:0] mz [NE];
   logic [16:0] m2 [NE];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
   endfunction

   task automatic push_exp(input logic [16:0] m [NE]);
      logic [19:0] x;
`ifdef MAT_PRINT_HEADER_EN
      logic [7:0] hdr [9] = '{8'h52, 8'h65, 8'h73, 8'h75, 8'h6C, 8'h74, 8'h3A, 8'h0D, 8'h0A};
      for (int i = 0; i < 9; i++) exp_q.push_back(hdr[i]);
`endif
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            x = {3'b000, m[r*DIM+c]};
            for (int d = 4; d >= 0; d--) exp_q.push_back(hexc(x[d*4 +: 4]));
            if (c < DIM-1) exp_q.push_back(8'h20);
            else begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
         end
   endtask

   task automatic load(input logic [16:0] m [NE]);
      for (int k = 0; k < NE; k++) C_mat[k*EW +: EW] = m[k];
   endtask

   // md: 0 = ready always high, 1 = stall at byte 10 then random; restart: re-pulse start at byte 20
   task automatic run(input logic [16:0] m [NE], input int md, input bit restart);
      int cyc, d0;
      bit got, pulsed;
      mode = md;
      push_exp(m);
      load(m);
      run_base = xfer_total;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (restart) C_mat = '1;
      cyc = 0; got = 0; pulsed = 0;
      while (!got && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1;
         else if (restart && !pulsed && xfer_total - run_base >= 20) begin
            start = 1'b1; pulsed = 1;
         end else start = 1'b0;
      end
      chk("done_seen", 32'(got), 1);
      if (md == 0) chk("done_cyc", cyc, NB+1);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after", 32'(busy), 0);
      chk("done_width", 32'(done), 0);
      chk("done_cnt", done_cnt - d0, 1);
      chk("byte_cnt", xfer_total - run_base, NB);
      chk("sb_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int cyc, d0;
      fork
         begin : monitor
            bit pend = 0;
            logic [7:0] pd = 8'h00;
            forever begin
               @(negedge clk);
               if (reset) pend = 0;
               else begin
                  if (pend) begin
                     chk("hold_valid", 32'(tx_valid), 1);
                     chk("hold_data", 32'(tx_data), 32'(pd));
                  end
                  if (tx_valid && tx_ready) begin
                     xfer_total++;
                     if (exp_q.size() > 0) chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                     else chk("sb_underrun", exp_q.size(), 1);
                  end
                  pend = tx_valid && !tx_ready;
                  pd   = tx_data;
                  if (done) done_cnt++;
               end
            end
         end
         begin : ready_drv
            int stall_left = 0;
            bit stalled = 0;
            forever begin
               @(posedge clk);
               #1;
               if (mode == 0) begin tx_ready = 1'b1; stalled = 0; stall_left = 0; end
               else if (stall_left > 0) begin tx_ready = 1'b0; stall_left--; end
               else if (!stalled && xfer_total - run_base == 10) begin
                  stalled = 1; stall_left = 4; tx_ready = 1'b0;
               end
               else tx_ready = stalled ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
         end
      join_none

      for (int k = 0; k < NE; k++) begin
         mz[k] = '0;
         m2[k] = 17'(k + 1);
      end
      m2[0] = 17'h1FFFF;

      #1;
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run(mz, 0, 0);
      run(m2, 0, 0);
      run(m2, 1, 0);
      run(m2, 0, 1);

      // abort mid-stream with an asynchronous reset
      mode = 0;
      push_exp(mz);
      load(mz);
      run_base = xfer_total;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      while (xfer_total - run_base < 30 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_30", xfer_total - run_base, 30);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("abort_valid", 32'(tx_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      repeat (3) @(negedge clk);
      chk("abort_nodone", done_cnt - d0, 0);
      exp_q.delete();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run(mz, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mat_print.md
Name: mat_print

Overview:
- Downstream consumer of the 3x3 matrix-multiply stage.
- Captures the 9x17-bit result matrix when the multiplier signals valid, formats it as ASCII hex text and streams it out one byte at a time over a valid/ready handshake to the UART transmitter.
- Decouples the multiplier from the slow serial link: once the matrix is captured, the multiplier is free to change its output.

Parameters:
- ELEM_W, 17, width of one result element.
- DIM, 3, matrix dimension (rows = columns = DIM).
- HEX_DIGITS, 5, hex digits printed per element (ceil(ELEM_W/4)).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  result-valid from multiplier; sampled only in IDLE.
- C_mat  input  [0:DIM*DIM*ELEM_W-1]  result matrix, row-major, element 0 at MSB end (bits 0:16).
- tx_data  output  8  ASCII byte to transmitter.
- tx_valid  output  1  tx_data holds a byte to send.
- tx_ready  input  1  transmitter accepts byte this cycle.
- busy  output  1  high from capture until last byte accepted.
- done  output  1  one-cycle pulse after final byte accepted.

Behaviour:
- Reset (async, immediate): tx_data=8'h00, tx_valid=0, busy=0, done=0, state=IDLE, counters=0, capture register=0.
- Transfer: a byte moves on a rising edge with tx_valid=1 and tx_ready=1.
- tx_valid never drops, and tx_data never changes, while a byte is pending and not yet accepted.
- IDLE:
  - On start=1, latch C_mat into the internal capture register and set busy=1.
  - Go to DIGIT (or HDR, see Optional Feature). tx_valid rises the cycle after start is sampled.
- start while busy is ignored. It is not queued.
- C_mat changes after capture have no effect on the output.
- Output format, per row r = 0..DIM-1:
  - For each element c = 0..DIM-1, emit HEX_DIGITS uppercase hex digits, MSB nibble first. The 17-bit value is zero-extended to 20 bits, so the top digit is '0' or '1'.
  - After elements 0..DIM-2, emit SEP = 8'h20 (space).
  - After the last element of a row, emit CR (8'h0D) then LF (8'h0A).
  - Total bytes = DIM*(DIM*HEX_DIGITS + DIM-1 + 2) = 57 for defaults.
- States and transitions (each advances only on transfer):
  - DIGIT: digit_idx counts HEX_DIGITS-1..0. At 0: go to SEP if col<DIM-1, else CR.
  - SEP: col++, back to DIGIT.
  - CR: go to LF.
  - LF: row++, col=0. If row was DIM-1, go to DONE, else DIGIT.
  - DONE: tx_valid=0, done=1 for exactly one cycle, busy=0, then IDLE.
- start=1 in the DONE cycle is ignored. It is accepted from IDLE on the next cycle.
- Hex mapping: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46.
- Reset mid-stream: abort immediately with no partial completion and no done pulse. The next start replays the full sequence from byte 0.
- tx_ready held high continuously: one byte per cycle, done at cycle 58 after start (57 data bytes + DONE).

Optional Feature:
- Macro: MAT_PRINT_HEADER_EN.
- Defined: after capture, state HDR first emits the 9 bytes "Result:" CR LF (8'h52 65 73 75 6C 74 3A 0D 0A), then enters DIGIT. Total 66 bytes.
- Undefined: HDR state and header ROM are absent, and capture goes straight to DIGIT.

Decomposition:
- Package mat_print_pkg holds:
  - ELEM_W, DIM and HEX_DIGITS defaults.
  - ASCII constants: SP, CR, LF, header string.
  - State enum: IDLE, HDR, DIGIT, SEP, CR, LF, DONE.
- One sub-module, nib2ascii: combinational 4-bit -> 8-bit ASCII, instantiated once on the selected nibble.
- Nibble select is an indexed part-select of the capture register by (row*DIM+col)*ELEM_W and digit_idx.

Test Plan:
- All-zero matrix, tx_ready=1 constant -> 57 bytes "00000 00000 00000\r\n" x3; done pulses once, exactly 58 cycles after start; busy low afterwards.
- Elements 1..9 with element 0 = 17'h1FFFF -> first row "1FFFF 00002 00003\r\n"; rows 2/3 "00004 00005 00006\r\n", "00007 00008 00009\r\n".
- Backpressure: tx_ready low for 5 cycles at byte 10 and randomly thereafter -> tx_data/tx_valid stable while stalled; byte sequence identical to no-stall run.
- start pulsed again at byte 20 and C_mat changed to all-ones after capture -> no restart, output still reflects captured matrix; single done pulse.
- reset asserted mid-cycle at byte 30 -> tx_valid, busy and done fall immediately, no done pulse; a subsequent start yields the full 57-byte sequence.
- With MAT_PRINT_HEADER_EN: zero matrix -> "Result:\r\n" followed by the 57 data bytes; done at cycle 67.
